ysyx_23060061_ifu: RTL and testbench

//  Instruction fetch unit; the upstream end of the IFU->IDEXU valid/ready link.

---
 rtl/ysyx_23060061_ifu.sv | 91 +++++++++
 tb/tb_ysyx_23060061_ifu.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060061_ifu.sv
// rtl/ysyx_23060061_ifu.sv - instruction fetch unit: one-at-a-time imem fetch feeding decode over valid/ready
module ysyx_23060061_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        ifu_valid,
  input  logic        idu_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic [31:0] dnpc,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_RSP,
    S_VAL
  } state_t;

  state_t state;
  state_t nextState;
  logic   rspFire;
  logic   idFire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_REQ;
    end else begin
      state <= nextState;
    end
  end

  // Handshake strobes depend only on registered state, so a response seen
  // outside S_RSP (e.g. left over from before a reset) is simply dropped.
  always_comb begin
    nextState      = state;
    imem_req_valid = 1'b0;
    ifu_valid      = 1'b0;
    rspFire        = 1'b0;
    idFire         = 1'b0;
    case (state)
      S_REQ: begin
        imem_req_valid = rst;
        if (imem_req_ready) nextState = S_RSP;
      end
      S_RSP: begin
        rspFire = imem_rsp_valid;
        if (imem_rsp_valid) nextState = S_VAL;
      end
      S_VAL: begin
        ifu_valid = 1'b1;
        idFire    = idu_ready;
        if (idu_ready) nextState = S_REQ;
      end
      default: nextState = S_REQ;
    endcase
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      inst      <= NOP;
      fetch_err <= 1'b0;
      fetch_cnt <= 32'd0;
    end else begin
      if (rspFire) begin
        inst <= imem_rsp_err ? NOP : imem_rsp_data;
        if (imem_rsp_err) fetch_err <= 1'b1;
      end
      if (idFire) begin
        // A misaligned target is forced to word alignment and flagged, not trapped.
        pc        <= {dnpc[31:2], 2'b00};
        fetch_cnt <= fetch_cnt + 32'd1;
        if (dnpc[1:0] != 2'b00) fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
// tb/tb_ysyx_23060061_ifu.sv - directed and randomized checks of the IFU against a transaction-level model
module tb_ysyx_23060061_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        imem_rsp_err = 1'b0;
  logic        ifu_valid;
  logic        idu_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] dnpc = 32'd0;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model: architectural state after each completed transaction.
  logic [31:0] mPc;
  logic [31:0] mInst;
  logic        mErr;
  logic [31:0] mCnt;

  ysyx_23060061_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .ifu_valid(ifu_valid), .idu_ready(idu_ready), .inst(inst), .pc(pc), .dnpc(dnpc),
    .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPc = RESET_PC; mInst = NOP; mErr = 1'b0; mCnt = 32'd0;
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_ifu_valid"}, 32'(ifu_valid), 32'd0);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_pc"}, pc, RESET_PC);
    chk({tag, "_inst"}, inst, NOP);
    chk({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
    chk({tag, "_fetch_cnt"}, fetch_cnt, 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; idu_ready = 1'b0;
    #1;
    checkResetOutputs("reset");
    step();
    modelReset();
    rst = 1'b1;
    #1;
  endtask

  // One full instruction: request (with stall), response (with wait), decode (with backpressure).
  task automatic fetchOne(input logic [31:0] data, input logic err, input int reqWait,
                          input int rspWait, input int iduWait, input logic [31:0] np,
                          input bit stalePulse, input bit noise);
    for (int i = 0; i < reqWait; i++) begin
      chk("req_valid_stall", 32'(imem_req_valid), 32'd1);
      chk("req_addr_stall", imem_addr, mPc);
      chk("ifu_valid_req", 32'(ifu_valid), 32'd0);
      imem_req_ready = 1'b0;
      imem_rsp_valid = stalePulse && (i == 1);
      imem_rsp_data  = 32'hDEAD_BEEF;
      idu_ready      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    chk("req_valid", 32'(imem_req_valid), 32'd1);
    chk("req_addr", imem_addr, mPc);
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    idu_ready      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < rspWait; i++) begin
      chk("ifu_valid_rsp", 32'(ifu_valid), 32'd0);
      chk("req_valid_rsp", 32'(imem_req_valid), 32'd0);
      idu_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = data; imem_rsp_err = err;
    idu_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    step();
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; idu_ready = 1'b0;
    if (err) mErr = 1'b1;
    mInst = err ? NOP : data;
    for (int i = 0; i < iduWait; i++) begin
      chk("ifu_valid_hold", 32'(ifu_valid), 32'd1);
      chk("inst_hold", inst, mInst);
      chk("pc_hold", pc, mPc);
      chk("req_valid_hold", 32'(imem_req_valid), 32'd0);
      step();
    end
    chk("ifu_valid", 32'(ifu_valid), 32'd1);
    chk("inst", inst, mInst);
    chk("pc", pc, mPc);
    chk("fetch_err_val", 32'(fetch_err), 32'(mErr));
    idu_ready = 1'b1; dnpc = np;
    step();
    idu_ready = 1'b0;
    mCnt = mCnt + 32'd1;
    if (np[1:0] != 2'b00) mErr = 1'b1;
    mPc = {np[31:2], 2'b00};
    chk("fetch_cnt", fetch_cnt, mCnt);
    chk("fetch_err", 32'(fetch_err), 32'(mErr));
    chk("ifu_valid_after", 32'(ifu_valid), 32'd0);
    chk("next_addr", imem_addr, mPc);
  endtask

  initial begin
    modelReset();
    step();
    doReset();

    // 1: zero-wait fetch of the reset vector
    fetchOne(32'h0000_0093, 1'b0, 0, 0, 0, 32'h8000_0004, 1'b0, 1'b0);
    // 2: decode backpressure for 10 cycles, then jump
    fetchOne(32'h0000_0113, 1'b0, 0, 0, 10, 32'h8000_0010, 1'b0, 1'b0);
    chk("t2_addr", imem_addr, 32'h8000_0010);
    // 3: request stall with a stale response pulse during the stall
    fetchOne(32'h1234_5678, 1'b0, 5, 0, 0, 32'h8000_0014, 1'b1, 1'b0);
    // 4: access fault delivers nop and sets sticky error
    fetchOne(32'hFFFF_FFFF, 1'b1, 0, 1, 0, 32'h8000_0018, 1'b0, 1'b0);
    fetchOne(32'h0000_0093, 1'b0, 0, 0, 0, 32'h8000_001C, 1'b0, 1'b0);
    chk("t4_sticky", 32'(fetch_err), 32'd1);

    // 5: misaligned dnpc from a clean state
    doReset();
    fetchOne(32'h0000_0093, 1'b0, 0, 0, 0, 32'h8000_0006, 1'b0, 1'b0);
    chk("t5_addr", imem_addr, 32'h8000_0004);
    chk("t5_err", 32'(fetch_err), 32'd1);

    // 6: reset while waiting for a response, then a late response arrives
    fetchOne(32'h0000_0093, 1'b0, 0, 0, 0, 32'h8000_0100, 1'b0, 1'b0);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    checkResetOutputs("t6_mid");
    step();
    modelReset();
    rst = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    step();
    imem_rsp_valid = 1'b0;
    chk("t6_ifu_valid", 32'(ifu_valid), 32'd0);
    chk("t6_pc", pc, RESET_PC);
    chk("t6_inst", inst, NOP);
    fetchOne(32'h0000_0293, 1'b0, 0, 2, 0, 32'h8000_0004, 1'b0, 1'b0);

    // Randomized traffic with idu_ready noise outside S_VAL
    doReset();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] np;
      np = $urandom;
      if ($urandom_range(0, 5) != 0) np[1:0] = 2'b00;
      fetchOne($urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), np, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
